// File: rtl/cache_fifo_pkg.sv
// Shared definitions for the cache line FIFO read arbiter: the default line
// width and the 2-bit transfer FSM encoding.
package cache_fifo_pkg;

    localparam int CASH_STR_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_RSP  = 2'd3
    } rd_state_e;

    // Requester 1 counts as last served out of reset, so requester 0 wins the first tie.
    localparam logic LAST_SRV_RST = 1'b1;

endpackage

// File: rtl/cache_fifo_rd_arbiter_if.sv
// Requester, FIFO read-side and status signals of the cache line read arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface cache_fifo_rd_arbiter_if
    import cache_fifo_pkg::*;
#(
    parameter int CASH_STR_WIDTH = CASH_STR_WIDTH_DEF
);
    logic [1:0]                req;
    logic [1:0]                ack;
    logic                      fifo_empty;
    logic [CASH_STR_WIDTH-1:0] fifo_dout;
    logic                      fifo_read;
    logic [1:0]                gnt;
    logic                      rsp_valid;
    logic [CASH_STR_WIDTH-1:0] rsp_data;
    logic                      busy;
    logic [15:0]               xfer_cnt;

    modport master (
        input  req, ack, fifo_empty, fifo_dout,
        output fifo_read, gnt, rsp_valid, rsp_data, busy, xfer_cnt
    );

    modport slave (
        output req, ack, fifo_empty, fifo_dout,
        input  fifo_read, gnt, rsp_valid, rsp_data, busy, xfer_cnt
    );

endinterface

// File: rtl/cache_fifo_rd_arbiter_rr_arbiter2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to
// the requester that was not served last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_srv,
    output logic [1:0] win
);

    // One-hot winner selection from the current requests and the last served index.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_srv ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_fifo_rd_arbiter.sv
// Arbitrates two requesters for single-line reads from a cache line FIFO,
// captures the line and holds it for the granted requester until acknowledged.
module cache_fifo_rd_arbiter
    import cache_fifo_pkg::*;
#(
    parameter int CASH_STR_WIDTH = CASH_STR_WIDTH_DEF
)(
    input  logic                    rd_clk,
    input  logic                    not_reset,
    cache_fifo_rd_arbiter_if.master bus
);

    rd_state_e                 state_r;
    logic [1:0]                gnt_r;
    logic                      rsp_valid_r;
    logic [CASH_STR_WIDTH-1:0] rsp_data_r;
    logic [15:0]               xfer_cnt_r;
    logic                      last_srv_r;
    logic [1:0]                win_s;

    rr_arbiter2 u_rr_arbiter2 (
        .req      (bus.req),
        .last_srv (last_srv_r),
        .win      (win_s)
    );

    // Transfer FSM with grant, line capture, response handshake and transfer counter.
    always_ff @(posedge rd_clk or negedge not_reset) begin
        if (!not_reset) begin
            state_r     <= ST_IDLE;
            gnt_r       <= 2'b00;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            xfer_cnt_r  <= 16'd0;
            last_srv_r  <= LAST_SRV_RST;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((|bus.req) && !bus.fifo_empty) begin
                        gnt_r   <= win_s;
                        state_r <= ST_RD;
                    end else begin
                        gnt_r   <= 2'b00;
                    end
                end
                ST_RD: begin
                    // The read strobe found the FIFO empty: abandon without serving anyone.
                    if (bus.fifo_empty) begin
                        gnt_r   <= 2'b00;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    rsp_data_r <= bus.fifo_dout;
                    state_r    <= ST_RSP;
                end
                ST_RSP: begin
                    // Valid rises one cycle after capture so it never leads stable data.
                    if (!rsp_valid_r) begin
                        rsp_valid_r <= 1'b1;
                    end else if (|(bus.ack & gnt_r)) begin
                        rsp_valid_r <= 1'b0;
                        gnt_r       <= 2'b00;
                        last_srv_r  <= gnt_r[1];
                        xfer_cnt_r  <= xfer_cnt_r + 16'd1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= 2'b00;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_read = (state_r == ST_RD);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.gnt       = gnt_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.xfer_cnt  = xfer_cnt_r;

endmodule
